// File: rtl/duty_setpoint_ctrl.sv
// Up/down duty-cycle setpoint register with edge-qualified stepping, hold-to-ramp
// auto-repeat, fine/coarse step select, clamped preset load and limit/change flags.
module duty_setpoint_ctrl #(
    parameter int WIDTH       = 10,
    parameter int MAX_VAL     = 1000,
    parameter int MIN_VAL     = 0,
    parameter int RST_VAL     = 0,
    parameter int COARSE_STEP = 25,
    parameter int FINE_STEP   = 1,
    parameter int HOLD_CYC    = 50,
    parameter int RPT_CYC     = 10
) (
    input  logic             clkm,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             fine,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] duty,
    output logic             at_max,
    output logic             at_min,
    output logic             changed
);

    localparam int CNT_MAX = (HOLD_CYC > RPT_CYC) ? HOLD_CYC : RPT_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] MIN_W = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0] RST_W = (WIDTH+1)'(RST_VAL);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             dir_reg, dir_next;
    logic             inc_q, dec_q;
    logic [WIDTH-1:0] duty_reg, duty_next;
    logic             at_max_reg, at_min_reg, changed_reg;

    logic             up, dn, up_edge, dn_edge, step_evt;
    logic [WIDTH:0]   step_w, duty_w, sum_w, up_val, dn_val, ld_w, ld_clamp, duty_sel;

    // Edges are taken on the raw buttons, so releasing one side of a conflict
    // never looks like a fresh press of the other.
    assign up      = inc & ~dec;
    assign dn      = dec & ~inc;
    assign up_edge = up & ~inc_q;
    assign dn_edge = dn & ~dec_q;

    // All arithmetic one bit wider than duty so a step can never wrap.
    assign step_w = fine ? (WIDTH+1)'(FINE_STEP) : (WIDTH+1)'(COARSE_STEP);
    assign duty_w = {1'b0, duty_reg};
    assign sum_w  = duty_w + step_w;
    assign up_val = (sum_w > MAX_W) ? MAX_W : sum_w;
    assign dn_val = (duty_w < (MIN_W + step_w)) ? MIN_W : (duty_w - step_w);

    assign ld_w     = {1'b0, load_val};
    assign ld_clamp = (ld_w > MAX_W) ? MAX_W : ((ld_w < MIN_W) ? MIN_W : ld_w);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        dir_next   = dir_reg;
        step_evt   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (up_edge || dn_edge) begin
                    step_evt   = 1'b1;
                    dir_next   = up_edge;
                    cnt_next   = CW'(1);
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (dir_reg ? up : dn) begin
                    if (cnt_reg == CW'(HOLD_CYC)) begin
                        step_evt   = 1'b1;
                        cnt_next   = CW'(1);
                        state_next = REPEAT;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end else begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            REPEAT: begin
                if (dir_reg ? up : dn) begin
                    if (cnt_reg == CW'(RPT_CYC)) begin
                        step_evt = 1'b1;
                        cnt_next = CW'(1);
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end else begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase

        duty_sel = duty_w;
        if (load) begin
            duty_sel   = ld_clamp;
            cnt_next   = '0;
            state_next = IDLE;
        end else if (step_evt) begin
            duty_sel = dir_next ? up_val : dn_val;
        end
        duty_next = duty_sel[WIDTH-1:0];
    end

    always_ff @(posedge clkm or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            dir_reg     <= 1'b0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            duty_reg    <= RST_W[WIDTH-1:0];
            at_max_reg  <= (RST_VAL == MAX_VAL);
            at_min_reg  <= (RST_VAL == MIN_VAL);
            changed_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            dir_reg     <= dir_next;
            inc_q       <= inc;
            dec_q       <= dec;
            duty_reg    <= duty_next;
            at_max_reg  <= ({1'b0, duty_next} == MAX_W);
            at_min_reg  <= ({1'b0, duty_next} == MIN_W);
            changed_reg <= (duty_next != duty_reg);
        end
    end

    assign duty    = duty_reg;
    assign at_max  = at_max_reg;
    assign at_min  = at_min_reg;
    assign changed = changed_reg;

endmodule

// File: tb/tb_duty_setpoint_ctrl.sv
// Directed self-checking bench for duty_setpoint_ctrl with default parameters
// (0..1000, coarse 25, fine 1, hold 50, repeat 10).
module tb_duty_setpoint_ctrl;

    logic       clkm = 1'b0;
    logic       reset = 1'b1;
    logic       inc = 1'b0, dec = 1'b0, fine = 1'b0, load = 1'b0;
    logic [9:0] load_val = '0;
    logic [9:0] duty;
    logic       at_max, at_min, changed;

    int checks = 0;
    int errors = 0;

    duty_setpoint_ctrl dut (
        .clkm(clkm), .reset(reset), .inc(inc), .dec(dec), .fine(fine),
        .load(load), .load_val(load_val), .duty(duty), .at_max(at_max),
        .at_min(at_min), .changed(changed)
    );

    always #5 clkm = ~clkm;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clkm);
        #1;
    endtask

    task automatic do_load(input logic [9:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (duty !== 10'd0) begin errors++; $display("FAIL reset_duty: got %0d expected 0", duty); end
        checks++; if (at_min !== 1'b1) begin errors++; $display("FAIL reset_at_min: got %b expected 1", at_min); end
        checks++; if (at_max !== 1'b0) begin errors++; $display("FAIL reset_at_max: got %b expected 0", at_max); end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL reset_changed: got %b expected 0", changed); end
        reset = 1'b0;
        tick();
        $display("test_reset: duty=%0d at_min=%b at_max=%b", duty, at_min, at_max);
    endtask

    task automatic test_single_pulse();
        fine = 1'b0;
        inc = 1'b1; tick();
        checks++; if (duty !== 10'd25) begin errors++; $display("FAIL pulse_duty: got %0d expected 25", duty); end
        checks++; if (changed !== 1'b1) begin errors++; $display("FAIL pulse_changed: got %b expected 1", changed); end
        inc = 1'b0; tick();
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL pulse_changed_once: got %b expected 0", changed); end
        for (int i = 0; i < 39; i++) begin
            inc = 1'b1; tick(); inc = 1'b0; tick();
        end
        checks++; if (duty !== 10'd1000) begin errors++; $display("FAIL pulse40_duty: got %0d expected 1000", duty); end
        checks++; if (at_max !== 1'b1) begin errors++; $display("FAIL pulse40_at_max: got %b expected 1", at_max); end
        inc = 1'b1; tick();
        checks++; if (duty !== 10'd1000) begin errors++; $display("FAIL pulse41_duty: got %0d expected 1000", duty); end
        checks++; if (changed !== 1'b0) begin errors++; $display("FAIL pulse41_changed: got %b expected 0", changed); end
        inc = 1'b0; tick();
        $display("test_single_pulse: duty=%0d at_max=%b", duty, at_max);
    endtask

    task automatic test_hold_ramp();
        do_load(10'd0);
        inc = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 49) begin
                checks++; if (duty !== 10'd25) begin errors++; $display("FAIL hold_before_repeat: got %0d expected 25", duty); end
            end
            if (i == 50) begin
                checks++; if (duty !== 10'd50) begin errors++; $display("FAIL hold_first_repeat: got %0d expected 50", duty); end
                checks++; if (changed !== 1'b1) begin errors++; $display("FAIL hold_repeat_changed: got %b expected 1", changed); end
            end
            if (i == 59) begin
                checks++; if (duty !== 10'd50) begin errors++; $display("FAIL hold_rpt_gap: got %0d expected 50", duty); end
            end
        end
        checks++; if (duty !== 10'd150) begin errors++; $display("FAIL hold_final: got %0d expected 150", duty); end
        inc = 1'b0; tick();
        $display("test_hold_ramp: duty=%0d", duty);
    endtask

    task automatic test_reset_mid_ramp();
        do_load(10'd475);
        inc = 1'b1; tick();
        checks++; if (duty !== 10'd500) begin errors++; $display("FAIL ramp_start: got %0d expected 500", duty); end
        repeat (10) tick();
        #2 reset = 1'b1;
        #1;
        checks++; if (duty !== 10'd0) begin errors++; $display("FAIL async_reset_duty: got %0d expected 0", duty); end
        checks++; if (at_min !== 1'b1) begin errors++; $display("FAIL async_reset_at_min: got %b expected 1", at_min); end
        inc = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        checks++; if (duty !== 10'd0) begin errors++; $display("FAIL reset_release_duty: got %0d expected 0", duty); end
        $display("test_reset_mid_ramp: duty=%0d", duty);
    endtask

    task automatic test_fine_dec();
        do_load(10'd3);
        fine = 1'b1;
        dec = 1'b1; tick(); dec = 1'b0;
        checks++; if (duty !== 10'd2) begin errors++; $display("FAIL fine_dec1: got %0d expected 2", duty); end
        tick();
        dec = 1'b1; tick(); dec = 1'b0; tick();
        checks++; if (duty !== 10'd1) begin errors++; $display("FAIL fine_dec2: got %0d expected 1", duty); end
        dec = 1'b1; tick(); dec = 1'b0;
        checks++; if (duty !== 10'd0 || at_min !== 1'b1) begin errors++; $display("FAIL fine_dec3: got %0d/%b expected 0/1", duty, at_min); end
        tick();
        dec = 1'b1; tick(); dec = 1'b0;
        checks++; if (duty !== 10'd0 || changed !== 1'b0) begin errors++; $display("FAIL fine_dec_sat: got %0d/%b expected 0/0", duty, changed); end
        tick();
        fine = 1'b0;
        do_load(10'd10);
        dec = 1'b1; tick(); dec = 1'b0;
        checks++; if (duty !== 10'd0 || at_min !== 1'b1) begin errors++; $display("FAIL coarse_dec_clamp: got %0d/%b expected 0/1", duty, at_min); end
        tick();
        $display("test_fine_dec: duty=%0d at_min=%b", duty, at_min);
    endtask

    task automatic test_conflict();
        do_load(10'd0);
        inc = 1'b1; dec = 1'b1;
        repeat (20) tick();
        checks++; if (duty !== 10'd0) begin errors++; $display("FAIL conflict_hold: got %0d expected 0", duty); end
        dec = 1'b0;
        repeat (60) tick();
        checks++; if (duty !== 10'd0) begin errors++; $display("FAIL conflict_release: got %0d expected 0", duty); end
        inc = 1'b0; tick();
        inc = 1'b1; tick();
        checks++; if (duty !== 10'd25) begin errors++; $display("FAIL conflict_repress: got %0d expected 25", duty); end
        inc = 1'b0; tick();
        $display("test_conflict: duty=%0d", duty);
    endtask

    task automatic test_load();
        load = 1'b1; load_val = 10'd1023; inc = 1'b1;
        tick();
        load = 1'b0;
        checks++; if (duty !== 10'd1000 || at_max !== 1'b1) begin errors++; $display("FAIL load_clamp: got %0d/%b expected 1000/1", duty, at_max); end
        checks++; if (changed !== 1'b1) begin errors++; $display("FAIL load_clamp_changed: got %b expected 1", changed); end
        inc = 1'b0; tick();
        // Load beats an inc edge; the held button must then stay idle past HOLD_CYC.
        load = 1'b1; load_val = 10'd500; inc = 1'b1;
        tick();
        load = 1'b0;
        repeat (60) tick();
        checks++; if (duty !== 10'd500) begin errors++; $display("FAIL load_idle: got %0d expected 500", duty); end
        inc = 1'b0; tick();
        do_load(10'd400);
        checks++; if (duty !== 10'd400 || changed !== 1'b1) begin errors++; $display("FAIL load_400: got %0d/%b expected 400/1", duty, changed); end
        do_load(10'd400);
        checks++; if (duty !== 10'd400 || changed !== 1'b0) begin errors++; $display("FAIL reload_400: got %0d/%b expected 400/0", duty, changed); end
        do_load(10'd990);
        inc = 1'b1; tick(); inc = 1'b0;
        checks++; if (duty !== 10'd1000 || at_max !== 1'b1) begin errors++; $display("FAIL clamp_990: got %0d/%b expected 1000/1", duty, at_max); end
        tick();
        $display("test_load: duty=%0d", duty);
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_hold_ramp();
        test_reset_mid_ramp();
        test_fine_dec();
        test_conflict();
        test_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
